data_memory_arbiter: RTL and testbench

- Shares the single data_memory instance between two requesters: the KGP-RISC datapath (CPU port) and an external loader/debug port (EXT port) used to preload and inspect data memory.
- Round-robin grant, one transaction at a time, fixed read latency, and a stall output that freezes the CPU (program counter and register-file write) while its access is pending.
- Sits between the datapath load/store path and data_memory.

---
 rtl/data_memory_arbiter_pkg.sv | 26 ++
 rtl/data_memory_arbiter_if.sv | 51 +++++
 rtl/data_memory_arbiter_rr_arbiter2.sv | 24 ++
 rtl/data_memory_arbiter.sv | 140 ++++++++++++++
 tb/tb_data_memory_arbiter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, port owners, alignment.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package data_memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_EXT = 1'b1
    } owner_t;

    localparam logic [1:0] ALIGN_MASK = 2'b11;
    localparam int         CNT_W      = 3;

    // Word accesses only: any set byte-offset bit makes the access illegal.
    function automatic logic is_aligned(input logic [1:0] addr_lo);
        return (addr_lo & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Bundles the CPU port, EXT port and data_memory side of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req until their done pulse.
interface data_memory_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_done;
    logic              cpu_err;
    logic              cpu_stall;

    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic [DATA_W-1:0] ext_rdata;
    logic              ext_done;
    logic              ext_err;

    logic              mem_enable;
    logic              mem_write_enable;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_data_out;

    // Arbiter view: serves both requesters and drives the memory.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_done, cpu_err, cpu_stall,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_rdata, ext_done, ext_err,
        output mem_enable, mem_write_enable, mem_address, mem_write_data,
        input  mem_data_out
    );

    // Requester / memory view.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_done, cpu_err, cpu_stall,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_rdata, ext_done, ext_err,
        input  mem_enable, mem_write_enable, mem_address, mem_write_data,
        output mem_data_out
    );

endinterface

// File: rtl/data_memory_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a tie goes to the port that did not own the last transaction.
// Latency: combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module rr_arbiter2
    import data_memory_arbiter_pkg::*;
(
    input  logic   cpu_req,
    input  logic   ext_req,
    input  owner_t last_owner,
    output logic   grant,
    output owner_t owner
);

    always_comb begin
        grant = cpu_req | ext_req;
        owner = OWNER_CPU;
        if (cpu_req && ext_req) begin
            owner = (last_owner == OWNER_CPU) ? OWNER_EXT : OWNER_CPU;
        end else if (ext_req) begin
            owner = OWNER_EXT;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares one data_memory between the CPU datapath and an EXT loader/debug port.
// Latency: request cycle N -> done at N+2 (store/misaligned) or N+2+MEM_LAT (load).
// Backpressure: one transaction at a time; cpu_stall holds the CPU while its access is pending.
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    data_memory_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    state_t            state_q;
    state_t            state_d;
    owner_t            owner_q;
    owner_t            last_owner_q;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] ext_rdata_q;

    logic              arb_grant;
    owner_t            arb_owner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              aligned;
    logic              in_done;

    rr_arbiter2 u_rr_arbiter2 (
        .cpu_req    (bus.cpu_req),
        .ext_req    (bus.ext_req),
        .last_owner (last_owner_q),
        .grant      (arb_grant),
        .owner      (arb_owner)
    );

    always_comb begin
        sel_we    = bus.cpu_we;
        sel_addr  = bus.cpu_addr;
        sel_wdata = bus.cpu_wdata;
        if (arb_owner == OWNER_EXT) begin
            sel_we    = bus.ext_we;
            sel_addr  = bus.ext_addr;
            sel_wdata = bus.ext_wdata;
        end
    end

    assign aligned = is_aligned(addr_q[1:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (arb_grant) state_d = ACCESS;
            ACCESS:  state_d = (we_q || !aligned) ? DONE : WAIT;
            WAIT:    if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Transaction latches, wait counter and per-port read-data registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q      <= OWNER_CPU;
            last_owner_q <= OWNER_EXT;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            cpu_rdata_q  <= '0;
            ext_rdata_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (arb_grant) begin
                        owner_q <= arb_owner;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                    end
                end
                ACCESS: begin
                    err_q <= ~aligned;
                    cnt_q <= LAT_LOAD;
                    // Stores and rejected accesses return zero read data.
                    if (we_q || !aligned) begin
                        if (owner_q == OWNER_CPU) cpu_rdata_q <= '0;
                        else                      ext_rdata_q <= '0;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        if (owner_q == OWNER_CPU) cpu_rdata_q <= bus.mem_data_out;
                        else                      ext_rdata_q <= bus.mem_data_out;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    last_owner_q <= owner_q;
                end
                default: ;
            endcase
        end
    end

    // Memory strobes decode straight from the state register so an async reset drops them at once.
    assign bus.mem_enable       = ((state_q == ACCESS) && aligned && !we_q) || (state_q == WAIT);
    assign bus.mem_write_enable = (state_q == ACCESS) && aligned && we_q;
    assign bus.mem_address      = addr_q;
    assign bus.mem_write_data   = wdata_q;

    assign in_done       = (state_q == DONE);
    assign bus.cpu_done  = in_done && (owner_q == OWNER_CPU);
    assign bus.ext_done  = in_done && (owner_q == OWNER_EXT);
    assign bus.cpu_err   = bus.cpu_done && err_q;
    assign bus.ext_err   = bus.ext_done && err_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.ext_rdata = ext_rdata_q;
    assign bus.cpu_stall = bus.cpu_req && !bus.cpu_done;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) with behavioural memories,
// directed transactions feeding an expected-response queue, and a done-driven checker.
module tb_data_memory_arbiter;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   cyc;
    int   checks;
    int   errors;
    exp_t qa[$];
    exp_t qb[$];

    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];
    logic [31:0] rd_a;
    logic [31:0] pb [0:2];

    data_memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifa ();
    data_memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifb ();

    data_memory_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa)
    );

    data_memory_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory with 1-cycle read latency; word 4 (0x10) preloaded while reset is held.
    always @(posedge clk) begin
        if (!rst_a) begin
            mem_a[4] <= 32'h0000_00AB;
        end else if (ifa.mem_write_enable) begin
            mem_a[ifa.mem_address[7:2]] <= ifa.mem_write_data;
        end
        rd_a <= mem_a[ifa.mem_address[7:2]];
    end
    assign ifa.mem_data_out = rd_a;

    // Memory with 3-cycle read latency; word 5 (0x14) preloaded while reset is held.
    always @(posedge clk) begin
        if (!rst_b) begin
            mem_b[5] <= 32'hCAFE_F00D;
        end else if (ifb.mem_write_enable) begin
            mem_b[ifb.mem_address[7:2]] <= ifb.mem_write_data;
        end
        pb[0] <= mem_b[ifb.mem_address[7:2]];
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign ifb.mem_data_out = pb[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic sb(input bit inst, input logic port, input logic [31:0] rd, input logic err);
        exp_t e;
        bit   have;
        have = inst ? (qb.size() != 0) : (qa.size() != 0);
        chk_b("done_was_expected", have, 1'b1);
        if (have) begin
            if (inst) e = qb.pop_front();
            else      e = qa.pop_front();
            chk_b("done_port", port, e.port);
            chk("done_rdata", rd, e.rdata);
            chk_b("done_err", err, e.err);
            chk("done_cycle", cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (ifa.cpu_done || ifa.ext_done) begin
            chk_b("a_single_done", ifa.cpu_done & ifa.ext_done, 1'b0);
            if (ifa.cpu_done) sb(1'b0, 1'b0, ifa.cpu_rdata, ifa.cpu_err);
            if (ifa.ext_done) sb(1'b0, 1'b1, ifa.ext_rdata, ifa.ext_err);
        end
        if (ifb.cpu_done) sb(1'b1, 1'b0, ifb.cpu_rdata, ifb.cpu_err);
        if (ifb.ext_done) sb(1'b1, 1'b1, ifb.ext_rdata, ifb.ext_err);
    end

    // One transaction on instance A; returns at the negedge where done was seen.
    task automatic a_xfer(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd,
                          input logic exp_err, input int lat,
                          output int en_cyc, output int we_cyc, output int we_off);
        int   n;
        bit   seen;
        logic d;
        @(negedge clk);
        n = cyc;
        qa.push_back('{port, exp_rd, exp_err, n + lat});
        if (!port) begin
            ifa.cpu_req = 1'b1; ifa.cpu_we = we; ifa.cpu_addr = addr; ifa.cpu_wdata = wdata;
            #1 chk_b("a_cpu_stall_issue", ifa.cpu_stall, 1'b1);
        end else begin
            ifa.ext_req = 1'b1; ifa.ext_we = we; ifa.ext_addr = addr; ifa.ext_wdata = wdata;
        end
        en_cyc = 0; we_cyc = 0; we_off = -1; seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ifa.mem_enable) en_cyc++;
            if (ifa.mem_write_enable) begin
                we_cyc++;
                we_off = cyc - n;
            end
            d = port ? ifa.ext_done : ifa.cpu_done;
            if (!port) chk_b("a_cpu_stall", ifa.cpu_stall, ~d);
            if (d) begin
                seen = 1;
                if (!port) ifa.cpu_req = 1'b0;
                else       ifa.ext_req = 1'b0;
                break;
            end
        end
        chk_b("a_done_seen", seen, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int en_c, we_c, we_o, n, cd, ed;
        checks = 0;
        errors = 0;
        ifa.cpu_req = 0; ifa.cpu_we = 0; ifa.cpu_addr = 0; ifa.cpu_wdata = 0;
        ifa.ext_req = 0; ifa.ext_we = 0; ifa.ext_addr = 0; ifa.ext_wdata = 0;
        ifb.cpu_req = 0; ifb.cpu_we = 0; ifb.cpu_addr = 0; ifb.cpu_wdata = 0;
        ifb.ext_req = 0; ifb.ext_we = 0; ifb.ext_addr = 0; ifb.ext_wdata = 0;
        rst_a = 0;
        rst_b = 0;
        repeat (3) @(negedge clk);
        #1;
        chk_b("rst_mem_enable", ifa.mem_enable, 1'b0);
        chk_b("rst_mem_we", ifa.mem_write_enable, 1'b0);
        chk("rst_mem_address", ifa.mem_address, 32'h0);
        chk("rst_mem_wdata", ifa.mem_write_data, 32'h0);
        chk_b("rst_cpu_done", ifa.cpu_done, 1'b0);
        chk_b("rst_ext_done", ifa.ext_done, 1'b0);
        chk_b("rst_cpu_err", ifa.cpu_err, 1'b0);
        chk_b("rst_cpu_stall", ifa.cpu_stall, 1'b0);
        chk("rst_cpu_rdata", ifa.cpu_rdata, 32'h0);
        chk("rst_ext_rdata", ifa.ext_rdata, 32'h0);
        @(negedge clk);
        rst_a = 1;
        rst_b = 1;
        repeat (2) @(negedge clk);

        // CPU load of 0x10 -> 0xAB, done at N+3.
        a_xfer(1'b0, 1'b0, 32'h10, 32'h0, 32'h0000_00AB, 1'b0, 3, en_c, we_c, we_o);
        chk("t1_enable_cycles", en_c, 2);
        chk("t1_we_cycles", we_c, 0);

        // EXT store 0x12345678 to 0x20, done at N+2, write strobe only in N+1.
        a_xfer(1'b1, 1'b1, 32'h20, 32'h1234_5678, 32'h0, 1'b0, 2, en_c, we_c, we_o);
        chk("t2_we_cycles", we_c, 1);
        chk("t2_we_offset", we_o, 1);
        chk("t2_enable_cycles", en_c, 0);
        chk("t2_cpu_rdata_held", ifa.cpu_rdata, 32'h0000_00AB);

        // Both requesting for four transactions: CPU, EXT, CPU, EXT, each a 4-cycle load.
        @(negedge clk);
        n = cyc;
        qa.push_back('{1'b0, 32'h1234_5678, 1'b0, n + 3});
        qa.push_back('{1'b1, 32'h0000_00AB, 1'b0, n + 7});
        qa.push_back('{1'b0, 32'h1234_5678, 1'b0, n + 11});
        qa.push_back('{1'b1, 32'h0000_00AB, 1'b0, n + 15});
        ifa.cpu_req = 1; ifa.cpu_we = 0; ifa.cpu_addr = 32'h20;
        ifa.ext_req = 1; ifa.ext_we = 0; ifa.ext_addr = 32'h10;
        cd = 0; ed = 0;
        for (int i = 0; i < 60 && (cd < 2 || ed < 2); i++) begin
            @(negedge clk);
            if (ifa.cpu_done) cd++;
            if (ifa.ext_done) ed++;
            if (cd == 2) ifa.cpu_req = 0;
            if (ed == 2) ifa.ext_req = 0;
        end
        chk("rr_cpu_dones", cd, 2);
        chk("rr_ext_dones", ed, 2);

        // Misaligned CPU load: no strobes, error at N+2, rdata cleared.
        a_xfer(1'b0, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 2, en_c, we_c, we_o);
        chk("t4_enable_cycles", en_c, 0);
        chk("t4_we_cycles", we_c, 0);
        chk("t4_ext_rdata_kept", ifa.ext_rdata, 32'h0000_00AB);

        // Reset during the WAIT of an EXT load aborts it without a done pulse.
        @(negedge clk);
        ifa.ext_req = 1; ifa.ext_we = 0; ifa.ext_addr = 32'h10;
        repeat (2) @(negedge clk);
        chk_b("t5_wait_enable", ifa.mem_enable, 1'b1);
        rst_a = 0;
        ifa.cpu_req = 1; ifa.cpu_we = 0; ifa.cpu_addr = 32'h20;
        #1;
        chk_b("t5_abort_enable", ifa.mem_enable, 1'b0);
        chk_b("t5_abort_we", ifa.mem_write_enable, 1'b0);
        chk_b("t5_abort_done", ifa.ext_done, 1'b0);
        chk("t5_abort_ext_rdata", ifa.ext_rdata, 32'h0);
        repeat (2) begin
            @(negedge clk);
            chk_b("t5_no_done_in_rst", ifa.ext_done, 1'b0);
        end
        n = cyc;
        qa.push_back('{1'b0, 32'h1234_5678, 1'b0, n + 3});
        qa.push_back('{1'b1, 32'h0000_00AB, 1'b0, n + 7});
        rst_a = 1;
        cd = 0; ed = 0;
        for (int i = 0; i < 40 && (cd < 1 || ed < 1); i++) begin
            @(negedge clk);
            if (ifa.cpu_done) begin cd++; ifa.cpu_req = 0; end
            if (ifa.ext_done) begin ed++; ifa.ext_req = 0; end
        end
        chk("t5_cpu_dones", cd, 1);
        chk("t5_ext_dones", ed, 1);

        // MEM_LAT=3: CPU load with request dropped after one cycle; later input changes ignored.
        @(negedge clk);
        n = cyc;
        qb.push_back('{1'b0, 32'hCAFE_F00D, 1'b0, n + 5});
        ifb.cpu_req = 1; ifb.cpu_we = 0; ifb.cpu_addr = 32'h14;
        @(negedge clk);
        ifb.cpu_req = 0; ifb.cpu_we = 1; ifb.cpu_addr = 32'h10; ifb.cpu_wdata = 32'hDEAD_BEEF;
        en_c = ifb.mem_enable ? 1 : 0;
        we_c = ifb.mem_write_enable ? 1 : 0;
        cd = 0;
        for (int i = 0; i < 20 && cd == 0; i++) begin
            @(negedge clk);
            if (ifb.mem_enable) en_c++;
            if (ifb.mem_write_enable) we_c++;
            if (ifb.cpu_done) cd++;
        end
        chk("t6_done_seen", cd, 1);
        chk("t6_enable_cycles", en_c, 4);
        chk("t6_we_cycles", we_c, 0);
        chk("t6_address_latched", ifb.mem_address, 32'h14);

        repeat (3) @(negedge clk);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
